// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, flag bit
// positions, FSM state type and a small opcode classification helper.
package alu_pkg;

    // ALU opcode encodings as understood by the shared ALU
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

    // Bit positions inside a {N,Z,V,C} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Arbiter sequencing: accept a request, let the ALU settle, hold the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // True for the opcodes whose second operand is a divisor
    function automatic logic isDivOp(input logic [3:0] sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

    // Flag pattern reported when a divide or modulo sees a zero divisor (Z and V set)
    function automatic logic [3:0] divZeroFlags();
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = 1'b1;
        f[FLAG_V] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. A lone requester always wins; on a tie
// the requester that did not win last time is granted. The remembered
// winner only moves when a grant is actually issued.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o,
    output logic grantValid_o,
    output logic grantId_o
);

    logic lastGrant_q;
    logic lastGrant_d;

    // Grant decision: lastGrant_q==1 means requester 1 won last, so requester 0 wins a tie
    always_comb begin
        grant0_o     = enable_i & valid0_i & (~valid1_i | lastGrant_q);
        grant1_o     = enable_i & valid1_i & (~valid0_i | ~lastGrant_q);
        grantValid_o = grant0_o | grant1_o;
        grantId_o    = grant1_o;
        lastGrant_d  = grantValid_o ? grantId_o : lastGrant_q;
    end

    // Remember the most recent winner; reset favours requester 0 on the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Execution-stage arbiter sharing one combinational ALU between two issue
// ports. A granted request is registered, driven onto the ALU for a full
// cycle, captured with its flags and then offered on a valid/ready response
// channel. Each requester owns an architectural {N,Z,V,C} flag register.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [3:0]           req0_sel,
    input  logic                 req0_setf,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic [3:0]           req1_sel,
    input  logic                 req1_setf,

    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [3:0]           alu_sel,
    input  logic [2*WIDTH-1:0]   alu_out,
    input  logic                 alu_n,
    input  logic                 alu_z,
    input  logic                 alu_v,
    input  logic                 alu_c,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,

    output logic [3:0]           flags0,
    output logic [3:0]           flags1
);

    arb_state_t           state_q;

    logic [WIDTH-1:0]     opA_q;
    logic [WIDTH-1:0]     opB_q;
    logic [3:0]           opSel_q;
    logic                 opSetf_q;
    logic                 opId_q;

    logic                 rspValid_q;
    logic [2*WIDTH-1:0]   rspData_q;
    logic [3:0]           rspFlags_q;
    logic                 rspErr_q;

    logic [3:0]           flags0_q;
    logic [3:0]           flags1_q;

    logic                 grant0;
    logic                 grant1;
    logic                 grantValid;
    logic                 grantId;

    logic [WIDTH-1:0]     opA_d;
    logic [WIDTH-1:0]     opB_d;
    logic [3:0]           opSel_d;
    logic                 opSetf_d;

    logic                 divZero;
    logic [2*WIDTH-1:0]   capData_d;
    logic [3:0]           capFlags_d;
    logic                 rspHandshake;
    logic                 flagWrite;

    rr_arbiter2 u_rr_arbiter2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (state_q == IDLE),
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .grant0_o     (grant0),
        .grant1_o     (grant1),
        .grantValid_o (grantValid),
        .grantId_o    (grantId)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Select the winning requester's payload for the operand registers
    always_comb begin
        opA_d    = grantId ? req1_a    : req0_a;
        opB_d    = grantId ? req1_b    : req0_b;
        opSel_d  = grantId ? req1_sel  : req0_sel;
        opSetf_d = grantId ? req1_setf : req0_setf;
    end

    // Build the captured result, replacing it with the error pattern on a zero divisor
    always_comb begin
        divZero            = isDivOp(opSel_q) && (opB_q == '0);
        capFlags_d         = 4'b0000;
        capFlags_d[FLAG_N] = alu_n;
        capFlags_d[FLAG_Z] = alu_z;
        capFlags_d[FLAG_V] = alu_v;
        capFlags_d[FLAG_C] = alu_c;
        capData_d          = alu_out;
        if (divZero) begin
            capData_d  = '0;
            capFlags_d = divZeroFlags();
        end
    end

    // Response acceptance and whether it should commit into a flag register
    always_comb begin
        rspHandshake = (state_q == RESP) && rspValid_q && rsp_ready;
        flagWrite    = rspHandshake && opSetf_q && !rspErr_q;
    end

    // Main sequencer: accept in IDLE, capture after the ALU cycle in EXEC, hand off in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            opSel_q    <= '0;
            opSetf_q   <= 1'b0;
            opId_q     <= 1'b0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspFlags_q <= '0;
            rspErr_q   <= 1'b0;
            flags0_q   <= '0;
            flags1_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantValid) begin
                        opA_q    <= opA_d;
                        opB_q    <= opB_d;
                        opSel_q  <= opSel_d;
                        opSetf_q <= opSetf_d;
                        opId_q   <= grantId;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rspData_q  <= capData_d;
                    rspFlags_q <= capFlags_d;
                    rspErr_q   <= divZero;
                    rspValid_q <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rspHandshake) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                        if (flagWrite && !opId_q) begin
                            flags0_q <= rspFlags_q;
                        end
                        if (flagWrite && opId_q) begin
                            flags1_q <= rspFlags_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = opA_q;
    assign alu_b     = opB_q;
    assign alu_sel   = opSel_q;

    assign rsp_valid = rspValid_q;
    assign rsp_id    = opId_q;
    assign rsp_data  = rspData_q;
    assign rsp_flags = rspFlags_q;
    assign rsp_err   = rspErr_q;

    assign flags0    = flags0_q;
    assign flags1    = flags1_q;

    // The two issue ports must never both see ready in the same cycle
    readyExclusive: assert property (@(posedge clk) disable iff (!rst_n) !(req0_ready && req1_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU standing in for the
// shared datapath ALU. Expected responses are hand-computed constants.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_setf;
    logic [11:0] req0_a, req0_b;
    logic [3:0]  req0_sel;
    logic        req1_valid, req1_ready, req1_setf;
    logic [11:0] req1_a, req1_b;
    logic [3:0]  req1_sel;
    logic [11:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [23:0] alu_out;
    logic        alu_n, alu_z, alu_v, alu_c;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [23:0] rsp_data;
    logic [3:0]  rsp_flags, flags0, flags1;
    logic [12:0] aluWide;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req0_setf  (req0_setf),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .req1_setf  (req1_setf),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .flags0     (flags0),
        .flags1     (flags1)
    );

    // Behavioural ALU; a zero divisor yields all-ones so the arbiter override is visible
    always_comb begin
        aluWide = '0;
        alu_out = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                aluWide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = {12'b0, aluWide[11:0]};
                alu_c   = aluWide[12];
                alu_v   = (alu_a[11] == alu_b[11]) && (aluWide[11] != alu_a[11]);
            end
            OP_SUB: begin
                aluWide = {1'b0, alu_a} - {1'b0, alu_b};
                alu_out = {12'b0, aluWide[11:0]};
                alu_c   = aluWide[12];
                alu_v   = (alu_a[11] != alu_b[11]) && (aluWide[11] != alu_a[11]);
            end
            OP_MUL: alu_out = {12'b0, alu_a} * {12'b0, alu_b};
            OP_DIV: begin
                if (alu_b != 12'd0) alu_out = {12'b0, alu_a / alu_b};
                else begin alu_out = '1; alu_c = 1'b1; end
            end
            OP_MOD: begin
                if (alu_b != 12'd0) alu_out = {12'b0, alu_a % alu_b};
                else begin alu_out = '1; alu_c = 1'b1; end
            end
            OP_AND: alu_out = {12'b0, alu_a & alu_b};
            OP_OR:  alu_out = {12'b0, alu_a | alu_b};
            OP_XOR: alu_out = {12'b0, alu_a ^ alu_b};
            OP_SHL: alu_out = {12'b0, alu_a << alu_b[3:0]};
            OP_SHR: alu_out = {12'b0, alu_a >> alu_b[3:0]};
            default: alu_out = '0;
        endcase
        alu_n = (alu_sel == OP_MUL) ? alu_out[23] : alu_out[11];
        alu_z = (alu_out == '0);
    end

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveReq(input bit id, input logic [11:0] a, input logic [11:0] b,
                            input logic [3:0] sel, input bit setf, input bit valid);
        if (id) begin
            req1_a = a; req1_b = b; req1_sel = sel; req1_setf = setf; req1_valid = valid;
        end else begin
            req0_a = a; req0_b = b; req0_sel = sel; req0_setf = setf; req0_valid = valid;
        end
    endtask

    task automatic clearReqs();
        driveReq(1'b0, 12'd0, 12'd0, 4'd0, 1'b0, 1'b0);
        driveReq(1'b1, 12'd0, 12'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearReqs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // One complete single-requester transaction; entered and left just after a negedge in IDLE
    task automatic applyStimulus(input string tag, input bit id, input logic [11:0] a, input logic [11:0] b,
                                 input logic [3:0] sel, input bit setf,
                                 input logic [23:0] expData, input logic [3:0] expFlags, input bit expErr);
        rsp_ready = 1'b1;
        driveReq(id, a, b, sel, setf, 1'b1);
        #1;
        checkOutput({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        checkOutput({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
        @(negedge clk);
        driveReq(id, 12'd0, 12'd0, 4'd0, 1'b0, 1'b0);
        #1;
        checkOutput({tag, "_exec_valid"}, rsp_valid, 0);
        checkOutput({tag, "_alu_a"}, alu_a, a);
        checkOutput({tag, "_alu_b"}, alu_b, b);
        checkOutput({tag, "_alu_sel"}, alu_sel, sel);
        @(negedge clk);
        #1;
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 1);
        checkOutput({tag, "_rsp_data"}, rsp_data, expData);
        checkOutput({tag, "_rsp_flags"}, rsp_flags, expFlags);
        checkOutput({tag, "_rsp_err"}, rsp_err, expErr);
        checkOutput({tag, "_rsp_id"}, rsp_id, id);
        @(negedge clk);
        #1;
        checkOutput({tag, "_done"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        clearReqs();
        @(negedge clk);
        applyReset();

        // Reset state
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_flags", rsp_flags, 0);
        checkOutput("rst_flags0", flags0, 0);
        checkOutput("rst_flags1", flags1, 0);
        checkOutput("rst_alu_sel", alu_sel, 0);

        // Lone ADD from requester 0
        applyStimulus("add", 1'b0, 12'd5, 12'd7, OP_ADD, 1'b1, 24'd12, 4'b0000, 1'b0);
        checkOutput("add_flags0", flags0, 4'b0000);
        checkOutput("add_flags1", flags1, 4'b0000);

        // Simultaneous requests after reset: requester 0 first, then round-robin to 1
        applyReset();
        rsp_ready = 1'b1;
        driveReq(1'b0, 12'd3, 12'd3, OP_SUB, 1'b1, 1'b1);
        driveReq(1'b1, 12'd64, 12'd64, OP_MUL, 1'b0, 1'b1);
        #1;
        checkOutput("tie_r0_ready", req0_ready, 1);
        checkOutput("tie_r1_ready", req1_ready, 0);
        @(negedge clk); #1;
        checkOutput("tie_exec_r1_ready", req1_ready, 0);
        @(negedge clk); #1;
        checkOutput("tie_sub_data", rsp_data, 0);
        checkOutput("tie_sub_flags", rsp_flags, 4'b0100);
        checkOutput("tie_sub_id", rsp_id, 0);
        @(negedge clk); #1;
        checkOutput("rr_r1_ready", req1_ready, 1);
        checkOutput("rr_r0_ready", req0_ready, 0);
        @(negedge clk);
        clearReqs();
        @(negedge clk); #1;
        checkOutput("rr_mul_valid", rsp_valid, 1);
        checkOutput("rr_mul_data", rsp_data, 24'd4096);
        checkOutput("rr_mul_id", rsp_id, 1);
        @(negedge clk); #1;
        checkOutput("rr_flags0", flags0, 4'b0100);
        checkOutput("rr_flags1", flags1, 4'b0000);

        // Flag updates and divide/modulo by zero
        applyStimulus("sub_neg", 1'b1, 12'd3, 12'd5, OP_SUB, 1'b1, 24'h000FFE, 4'b1001, 1'b0);
        checkOutput("sub_neg_flags1", flags1, 4'b1001);
        applyStimulus("div0", 1'b1, 12'd100, 12'd0, OP_DIV, 1'b1, 24'd0, 4'b0110, 1'b1);
        checkOutput("div0_flags1", flags1, 4'b1001);
        applyStimulus("mul_max", 1'b0, 12'hFFF, 12'hFFF, OP_MUL, 1'b1, 24'hFFE001, 4'b1000, 1'b0);
        checkOutput("mul_max_flags0", flags0, 4'b1000);
        applyStimulus("mod0", 1'b0, 12'd7, 12'd0, OP_MOD, 1'b1, 24'd0, 4'b0110, 1'b1);
        checkOutput("mod0_flags0", flags0, 4'b1000);
        applyStimulus("unknown", 1'b1, 12'd1, 12'd2, 4'b1111, 1'b0, 24'd0, 4'b0100, 1'b0);
        checkOutput("unknown_flags1", flags1, 4'b1001);

        // Backpressure: response held for five cycles with a competing request pending
        rsp_ready = 1'b0;
        driveReq(1'b0, 12'hF0F, 12'h0FF, OP_AND, 1'b0, 1'b1);
        #1;
        checkOutput("bp_r0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        driveReq(1'b1, 12'd1, 12'd1, OP_ADD, 1'b0, 1'b1);
        #1;
        checkOutput("bp_exec_r1_ready", req1_ready, 0);
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_valid_%0d", i), rsp_valid, 1);
            checkOutput($sformatf("bp_data_%0d", i), rsp_data, 24'h00000F);
            checkOutput($sformatf("bp_r0_ready_%0d", i), req0_ready, 0);
            checkOutput($sformatf("bp_r1_ready_%0d", i), req1_ready, 0);
            @(negedge clk); #1;
        end
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk); #1;
        checkOutput("bp_release", rsp_valid, 0);

        // Reset while an XOR is executing abandons it
        driveReq(1'b0, 12'h0F0, 12'h00F, OP_XOR, 1'b1, 1'b1);
        #1;
        checkOutput("rstx_r0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        checkOutput("rstx_exec_alu_a", alu_a, 12'h0F0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstx_rsp_valid", rsp_valid, 0);
        checkOutput("rstx_flags0", flags0, 4'b0000);
        checkOutput("rstx_alu_a", alu_a, 0);
        applyStimulus("fresh", 1'b1, 12'd1, 12'd2, OP_ADD, 1'b0, 24'd3, 4'b0000, 1'b0);

        // Both requesters always valid: grants alternate 0,1,0,1
        rsp_ready = 1'b1;
        driveReq(1'b0, 12'd10, 12'd20, OP_ADD, 1'b0, 1'b1);
        driveReq(1'b1, 12'd1, 12'd4, OP_SHL, 1'b0, 1'b1);
        #1;
        for (int k = 0; k < 4; k++) begin
            bit expId;
            expId = bit'(k % 2);
            checkOutput($sformatf("alt_r0_ready_%0d", k), req0_ready, (expId == 1'b0));
            checkOutput($sformatf("alt_r1_ready_%0d", k), req1_ready, (expId == 1'b1));
            @(negedge clk); #1;
            @(negedge clk); #1;
            checkOutput($sformatf("alt_valid_%0d", k), rsp_valid, 1);
            checkOutput($sformatf("alt_id_%0d", k), rsp_id, expId);
            checkOutput($sformatf("alt_data_%0d", k), rsp_data, expId ? 24'd16 : 24'd30);
            @(negedge clk); #1;
        end
        clearReqs();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
